// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder
//   Turns the raw set-2 scancode byte stream from ps2_keyboard into key
//   events. Bytes are fetched through the ready/nextdata_n handshake. The
//   E0 (extended), F0 (break) and E1 (pause) prefixes are parsed, and each
//   key action is queued as {code,ext,brk,rpt} in a show-ahead FIFO. The
//   block also tracks the held key, the press count and two sticky error
//   flags.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   byte_data/ready   scancode byte and not-empty flag from ps2_keyboard
//   byte_overflow     upstream overflow; aborts parsing and fetching
//   byte_nextdata_n   active-low pop strobe back to ps2_keyboard
//   evt_valid/ready   event FIFO handshake (pop on valid && ready)
//   evt_code/ext/brk/rpt  head event fields, valid while evt_valid=1
//   key_held, held_code   key currently down and its {ext,code}
//   press_count       non-repeat makes since reset (wraps)
//   err_overflow/drop sticky error flags, cleared by clr_err
module ps2_key_event_decoder #(
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 8,
  parameter bit REPORT_RPT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       byte_data,
  input  logic             byte_ready,
  input  logic             byte_overflow,
  output logic             byte_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_brk,
  output logic             evt_rpt,
  output logic             key_held,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             err_overflow,
  output logic             err_drop,
  input  logic             clr_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {F_IDLE, F_ACK, F_WAIT} fetch_t;
  typedef enum logic [2:0] {P_BASE, P_EXT, P_BRK, P_EXTBRK, P_PAUSE} parse_t;

  fetch_t fetch_q, fetch_d;
  parse_t parse_q, parse_d;
  logic [7:0] byte_q;
  logic [2:0] skip_q, skip_d;

  logic byte_act;
  logic push, push_ext, push_brk, push_rpt;
  logic is_make, make_ext;
  logic held_d;
  logic [8:0] held_code_d;
  logic [CNT_W-1:0] count_d;

  logic [10:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  logic full, pop, wr_en, drop;

  // The latched byte is acted on only in ACK, and an overflow in that same
  // cycle suppresses both the parse and the upstream pop.
  assign byte_act        = (fetch_q == F_ACK) && !byte_overflow;
  assign byte_nextdata_n = !byte_act;

  // Fetch sequencer: IDLE -> ACK -> WAIT -> IDLE, forced to IDLE on overflow.
  always_comb begin
    fetch_d = fetch_q;
    unique case (fetch_q)
      F_IDLE:  if (byte_ready) fetch_d = F_ACK;
      F_ACK:   fetch_d = F_WAIT;
      default: fetch_d = F_IDLE;
    endcase
    if (byte_overflow) fetch_d = F_IDLE;
  end

  // Prefix parser and held-key bookkeeping for the byte being acknowledged.
  always_comb begin
    parse_d     = parse_q;
    skip_d      = skip_q;
    push        = 1'b0;
    push_ext    = 1'b0;
    push_brk    = 1'b0;
    push_rpt    = 1'b0;
    is_make     = 1'b0;
    make_ext    = 1'b0;
    held_d      = key_held;
    held_code_d = held_code;
    count_d     = press_count;
    if (byte_act) begin
      unique case (parse_q)
        P_BASE: begin
          if (byte_q == 8'hE0) parse_d = P_EXT;
          else if (byte_q == 8'hF0) parse_d = P_BRK;
          else if (byte_q == 8'hE1) begin
            push    = 1'b1;
            parse_d = P_PAUSE;
            skip_d  = 3'd7;
          end else is_make = 1'b1;
        end
        P_EXT: begin
          if (byte_q == 8'hF0) parse_d = P_EXTBRK;
          else if (byte_q != 8'hE0) begin
            is_make  = 1'b1;
            make_ext = 1'b1;
            parse_d  = P_BASE;
          end
        end
        P_BRK, P_EXTBRK: begin
          push     = 1'b1;
          push_brk = 1'b1;
          push_ext = (parse_q == P_EXTBRK);
          // Releasing a key other than the held one leaves held state alone.
          if (held_code == {push_ext, byte_q}) held_d = 1'b0;
          parse_d  = P_BASE;
        end
        P_PAUSE: begin
          // The rest of the pause sequence carries no information.
          if (skip_q <= 3'd1) parse_d = P_BASE;
          skip_d = skip_q - 3'd1;
        end
        default: parse_d = P_BASE;
      endcase
      if (is_make) begin
        push_ext = make_ext;
        if (key_held && held_code == {make_ext, byte_q}) begin
          push     = REPORT_RPT;
          push_rpt = 1'b1;
        end else begin
          push        = 1'b1;
          held_d      = 1'b1;
          held_code_d = {make_ext, byte_q};
          count_d     = press_count + CNT_W'(1);
        end
      end
    end
    if (byte_overflow) begin
      parse_d = P_BASE;
      skip_d  = 3'd0;
    end
  end

  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign evt_valid = (occ != '0);
  assign full      = (occ == OCC_W'(DEPTH));
  assign pop       = evt_valid && evt_ready;
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  assign {evt_code, evt_ext, evt_brk, evt_rpt} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {byte_q, push_ext, push_brk, push_rpt};
  end

  // Sequencer, parser, key tracking, FIFO pointers and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_q      <= F_IDLE;
      parse_q      <= P_BASE;
      byte_q       <= 8'h00;
      skip_q       <= 3'd0;
      key_held     <= 1'b0;
      held_code    <= 9'h000;
      press_count  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      err_overflow <= 1'b0;
      err_drop     <= 1'b0;
    end else begin
      fetch_q     <= fetch_d;
      parse_q     <= parse_d;
      skip_q      <= skip_d;
      key_held    <= held_d;
      held_code   <= held_code_d;
      press_count <= count_d;
      if (fetch_q == F_IDLE && byte_ready && !byte_overflow) byte_q <= byte_data;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !pop)      occ <= occ + OCC_W'(1);
      else if (pop && !wr_en) occ <= occ - OCC_W'(1);
      // A set condition takes priority over a clear in the same cycle.
      if (byte_overflow) err_overflow <= 1'b1;
      else if (clr_err)  err_overflow <= 1'b0;
      if (drop)          err_drop <= 1'b1;
      else if (clr_err)  err_drop <= 1'b0;
    end
  end

endmodule
